// File: rtl/lsu_multicycle.sv
// lsu_multicycle
//   Multi-cycle load/store unit sitting between execute/writeback and the
//   shared memory port. It accepts one load or store per transaction. Stores
//   are shifted into the addressed byte lanes and get matching byte enables.
//   Loads pull the addressed lane out of the aligned word and sign- or
//   zero-extend it. Misaligned or illegal-size accesses never reach memory.
//   A REQ/WAIT that runs too long is aborted with a timeout error.
//
//   State table
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | ready for a request; req_ready high unless rst
//   S_REQ  | mem_valid high, address/data/enables held until mem_ready
//   S_WAIT | load handshaken, waiting for mem_rvalid
//   S_RESP | one-cycle rsp_valid pulse, then back to S_IDLE
//
//   Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_store, req_size,          operation, log2 byte size, sign-extend,
//   req_signed, req_addr,         byte address and right-justified
//   req_wdata                     store data
//   mem_valid/mem_ready           memory request handshake
//   mem_we, mem_addr, mem_wdata,  write strobe, aligned address, lane-shifted
//   mem_be                        store data, byte enables
//   mem_rvalid, mem_rdata         load return (aligned full word)
//   rsp_valid, rsp_rdata, rsp_err completion pulse, extended load data,
//                                 error (0 ok, 1 misaligned/illegal, 2 timeout)
module lsu_multicycle #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [1:0]        rsp_err
);

  localparam int NB    = XLEN / 8;
  localparam int OFS_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ALIGN   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state;
  logic             store_q;
  logic             signed_q;
  logic [1:0]       size_q;
  logic [OFS_W-1:0] ofs_q;
  logic [CNT_W-1:0] cnt_q;

  logic [OFS_W-1:0]  req_ofs;
  logic              req_bad;
  logic [ADDR_W-1:0] req_addr_al;
  logic [XLEN-1:0]   st_data;
  logic [NB-1:0]     st_be;
  logic [XLEN-1:0]   ld_mask;
  logic [XLEN-1:0]   ld_lane;
  logic              ld_sign;
  logic [XLEN-1:0]   ld_data;
  logic              timeout_hit;

  // All-ones over the low 2^sz bytes.
  function automatic logic [XLEN-1:0] lane_mask(input logic [1:0] sz);
    logic [XLEN-1:0] m;
    m = '0;
    for (int b = 0; b < NB; b++) begin
      if (b < (1 << sz)) m[8*b +: 8] = 8'hFF;
    end
    return m;
  endfunction

  function automatic logic [NB-1:0] byte_en(input logic [1:0] sz,
                                            input logic [OFS_W-1:0] ofs);
    logic [NB-1:0] be;
    be = '0;
    for (int b = 0; b < NB; b++) begin
      if (b >= int'(ofs) && b < int'(ofs) + (1 << sz)) be[b] = 1'b1;
    end
    return be;
  endfunction

  assign req_ready = (state == S_IDLE) && !rst;

  always_comb begin
    req_ofs     = req_addr[OFS_W-1:0];
    req_bad     = ((1 << req_size) > NB) ||
                  ((int'(req_ofs) & ((1 << req_size) - 1)) != 0);
    req_addr_al = {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
    st_data     = (req_wdata & lane_mask(req_size)) << {req_ofs, 3'b000};
    st_be       = byte_en(req_size, req_ofs);

    ld_mask = lane_mask(size_q);
    ld_lane = (mem_rdata >> {ofs_q, 3'b000}) & ld_mask;
    // ld_mask is contiguous from bit 0, so ~(ld_mask >> 1) leaves only its
    // top bit set: that picks out the lane's sign bit without indexing.
    ld_sign = signed_q & (|(ld_lane & ~(ld_mask >> 1)));
    ld_data = ld_lane | (ld_sign ? ~ld_mask : '0);

    // cnt_q counts completed REQ/WAIT cycles, so TIMEOUT-1 marks the last
    // allowed one. A load handshaken on that cycle enters WAIT past the limit
    // and gets exactly one chance to see mem_rvalid.
    timeout_hit = (cnt_q >= CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      store_q   <= 1'b0;
      signed_q  <= 1'b0;
      size_q    <= 2'd0;
      ofs_q     <= '0;
      cnt_q     <= '0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= ERR_OK;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            store_q  <= req_store;
            signed_q <= req_signed;
            size_q   <= req_size;
            ofs_q    <= req_ofs;
            if (req_bad) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= ERR_ALIGN;
              rsp_rdata <= '0;
            end else begin
              state     <= S_REQ;
              cnt_q     <= '0;
              mem_valid <= 1'b1;
              mem_we    <= req_store;
              mem_addr  <= req_addr_al;
              mem_be    <= st_be;
              mem_wdata <= req_store ? st_data : '0;
            end
          end
        end

        S_REQ: begin
          if (mem_ready || timeout_hit) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
          end
          if (mem_ready) begin
            if (store_q) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= ERR_OK;
              rsp_rdata <= '0;
            end else begin
              state <= S_WAIT;
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (timeout_hit) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= ERR_TIMEOUT;
            rsp_rdata <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_WAIT: begin
          if (mem_rvalid) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= ERR_OK;
            rsp_rdata <= ld_data;
          end else if (timeout_hit) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= ERR_TIMEOUT;
            rsp_rdata <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_RESP: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_multicycle.md
# lsu_multicycle

Parametrised multi-cycle load/store unit between the core's execute/writeback stages and the shared instruction/data memory port. It takes one load or store per transaction and aligns store data into byte lanes with matching byte enables. On loads it extracts the addressed lane and sign- or zero-extends the result. It also flags misaligned accesses and memory timeouts, replacing the fixed 32-bit byte-select/extension mux path with a handshaked, width-generic unit.

## Interface
- XLEN, 32: data width, 32 or 64; NB = XLEN/8 byte lanes, OFS_W = log2(NB).
- ADDR_W, 32: byte-address width.
- TIMEOUT, 16: maximum cycles spent in REQ+WAIT before aborting; must be ≥ 2.

- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  transaction request.
- req_ready  out  1  unit idle, request accepted when req_valid & req_ready.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 double (legal only when XLEN=64).
- req_signed  in  1  1 = sign-extend load, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- mem_valid  out  1  memory request.
- mem_ready  in  1  memory accepts request this cycle.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  req_addr with low OFS_W bits cleared.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_be  out  NB  byte enables.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  XLEN  full aligned load word.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  XLEN  extended load result.
- rsp_err  out  2  0 ok, 1 misaligned/illegal size, 2 timeout.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready = 1 (forced 0 while rst). On accept, latch all req_* fields.
  - Misaligned (addr mod 2^size ≠ 0) or size 3 with XLEN=32 → RESP, err 1, no memory access.
  - Otherwise → REQ.
- REQ: mem_valid = 1. mem_addr, mem_we, mem_wdata and mem_be are registered and stable until handshake.
  - On mem_ready: a store → RESP with err 0; a load → WAIT.
- WAIT: on mem_rvalid:
  - lane = mem_rdata >> (8·ofs), ofs = addr[OFS_W-1:0];
  - keep low 8·2^size bits, extend to XLEN per req_signed;
  - → RESP.
- mem_rvalid is ignored in IDLE, REQ and RESP. The memory must return load data ≥ 1 cycle after the handshake.
- Stores: mem_be = ((1<<2^size)−1) << ofs. mem_wdata = (req_wdata masked to size) << (8·ofs). Lanes outside mem_be are 0.
- Timeout counter:
  - cleared on entering REQ, increments every REQ/WAIT cycle.
  - On the TIMEOUT-th such cycle with no completing event: → RESP, err 2, mem_valid drops.
  - Completion in the same cycle as expiry wins (err 0).
- RESP: rsp_valid = 1 for exactly one cycle, then → IDLE.
  - rsp_rdata = 0 for stores and errors.
  - rsp_rdata and rsp_err hold until the next RESP.
- Reset (any state, including mid-transaction):
  - next state IDLE; the abandoned transaction produces no rsp_valid.
  - mem_valid, mem_we, mem_be, mem_wdata, mem_addr, rsp_valid, rsp_rdata and rsp_err are all 0.
  - counter is 0.

## Timing
- Accept at edge N.
  - Misaligned: rsp_valid in cycle N+1.
  - Otherwise mem_valid is first high in cycle N+1.
- mem_ready high in cycle N+1:
  - store rsp_valid in cycle N+2;
  - load enters WAIT in cycle N+2, and mem_rvalid in cycle N+2 gives rsp_valid in cycle N+3 (minimum load latency 3).
- Each cycle of mem_ready low or mem_rvalid delay adds exactly one cycle.
- req_ready is low from N+1 until the cycle after RESP. Back-to-back issue is therefore possible every 3 cycles (stores) or 4 cycles (loads) minimum.
- All outputs are registered, except req_ready, which is decoded from state and rst.

## Test plan
- XLEN=32 signed lb @0x1003, mem_rdata 0x80FF1234 → mem_addr 0x1000, rsp_rdata 0xFFFFFF80, err 0, rsp_valid at N+3. The same access unsigned → 0x00000080.
- sh @0x2002, wdata 0xDEADBEEF → mem_addr 0x2000, mem_be 4'b1100, mem_wdata 0xBEEF0000, mem_we 1, rsp_valid at N+2.
- lw @0x1002 → rsp_err 1 at N+1, mem_valid never asserted. Under XLEN=32, size 3 @0x0 → err 1. Under XLEN=64, ld @0x8 → err 0 with the full 64-bit result.
- mem_ready low for 3 cycles → mem_valid, mem_addr, mem_be and mem_wdata constant across all 4 REQ cycles; rsp_valid 3 cycles later than nominal.
- TIMEOUT=16 load, mem_rvalid never asserted → rsp_err 2 and rsp_rdata 0 in the cycle after the 16th REQ/WAIT cycle. A following lbu @0x0 completes normally.
- rst pulsed while in WAIT → next cycle IDLE with all outputs 0 and req_ready 1. A later stray mem_rvalid produces no rsp_valid.
